ov7670_capture: RTL

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: turns the camera byte stream into 12-bit frame buffer writes.
// Define OV7670_CAPTURE_STATS_EN to add the frame_count / frame_err statistics outputs.
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  output logic [18:0] addr,
  output logic [11:0] dout,
  output logic        we,
  output logic        frame_done
`ifdef OV7670_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic        frame_err
`endif
);

  localparam int PIX_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 2);

  localparam logic [18:0]       ADDR_LAST = 19'(H_PIXELS * V_LINES - 1);
  localparam logic [PIX_W-1:0]  PIX_LIM   = PIX_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_LIM  = LINE_W'(V_LINES);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    LINE
  } state_t;

  state_t state, state_nxt;

  logic              vsync_q, href_q, vsync_p;
  logic [7:0]        d_q;
  logic              vsync_rise;
  logic              clear, byte_en, end_line, frame_done_nxt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              phase;
  logic [3:0]        red;

  assign vsync_rise     = vsync_q && !vsync_p;
  assign frame_done_nxt = vsync_rise && (state != SYNC);

  // vsync_p is the previous registered vsync, used only for edge detection.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
      vsync_p <= 1'b0;
      state   <= SYNC;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      vsync_q <= vsync;
      href_q  <= href;
      d_q     <= d;
      vsync_p <= vsync_q;
      state   <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    clear     = 1'b0;
    byte_en   = 1'b0;
    end_line  = 1'b0;
    unique case (state)
      SYNC: begin
        if (vsync_rise) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
      IDLE: begin
        if (vsync_q) begin
          clear = 1'b1;
        end else if (href_q) begin
          // The byte sampled with the first high href is already the red byte.
          state_nxt = LINE;
          byte_en   = 1'b1;
        end
      end
      LINE: begin
        if (vsync_q) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end else if (!href_q) begin
          state_nxt = IDLE;
          end_line  = 1'b1;
        end else begin
          byte_en = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      phase      <= 1'b0;
      red        <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= frame_done_nxt;
      if (we && addr != ADDR_LAST) addr <= addr + 19'd1;
      if (clear) begin
        addr     <= '0;
        pix_cnt  <= '0;
        line_cnt <= '0;
        phase    <= 1'b0;
      end else if (end_line) begin
        pix_cnt <= '0;
        phase   <= 1'b0;
        if (line_cnt != '1) line_cnt <= line_cnt + LINE_W'(1);
      end else if (byte_en) begin
        phase <= ~phase;
        if (!phase) begin
          red <= d_q[3:0];
        end else if (pix_cnt < PIX_LIM && line_cnt < LINE_LIM) begin
          we      <= 1'b1;
          dout    <= {red, d_q};
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end
    end
  end

`ifdef OV7670_CAPTURE_STATS_EN
  localparam int BYTE_W = $clog2(2 * H_PIXELS + 2);
  localparam logic [BYTE_W-1:0] BYTE_LINE = BYTE_W'(2 * H_PIXELS);

  logic [BYTE_W-1:0] byte_cnt;
  logic              err_acc;

  // frame_err flags a bad line immediately; at frame_done it takes the whole frame's verdict.
  always_ff @(posedge pclk) begin
    if (rst) begin
      byte_cnt    <= '0;
      err_acc     <= 1'b0;
      frame_count <= '0;
      frame_err   <= 1'b0;
    end else begin
      if (clear || end_line) byte_cnt <= '0;
      else if (byte_en && byte_cnt != '1) byte_cnt <= byte_cnt + BYTE_W'(1);
      if (frame_done_nxt) begin
        frame_count <= frame_count + 16'd1;
        frame_err   <= err_acc || (line_cnt != LINE_LIM);
        err_acc     <= 1'b0;
      end else if (end_line && byte_cnt != BYTE_LINE) begin
        frame_err <= 1'b1;
        err_acc   <= 1'b1;
      end
    end
  end
`endif

endmodule
